// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared state encoding and helpers for the radix-2 divider
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    // Magnitude of an operand; only a negative value in a signed divide is negated.
    function automatic logic [31:0] abs_val(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit restoring divider for DIV/DIVU, result {remainder, quotient}
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        neg_quot;
    logic        neg_rem;

    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        diff     = {1'b0, work[63:32]} - {1'b0, divisor};
        quot_fix = neg_quot ? (~work[31:0] + 32'd1) : work[31:0];
        rem_fix  = neg_rem ? (~work[64:33] + 32'd1) : work[64:33];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state    <= DIV_ON;
                            cnt      <= 6'd0;
                            work     <= {32'd0, abs_val(signed_div_i, opdata1_i), 1'b0};
                            divisor  <= abs_val(signed_div_i, opdata2_i);
                            neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem  <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state    <= DIV_END;
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                end
                DIV_ON: begin
                    if (annul_i || !start_i) begin
                        state    <= DIV_FREE;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else if (cnt != DIV_ITERS) begin
                        // Restore by simply shifting when the trial subtract goes negative.
                        if (diff[32])
                            work <= work << 1;
                        else
                            work <= {diff[31:0], work[31:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        state    <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state    <= DIV_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
